// File: rtl/npu_bus_master.sv
// npu_bus_master: host-side initiator for the NPU memory-mapped port.
// Turns WRITE / READ / POLL command words into single-cycle ena/wea/addra/dina
// bus transactions and returns douta results on a response stream.
// Optional feature macro: NPU_BUS_POLL_TIMEOUT_EN (bounds POLL to POLL_MAX reads).
module npu_bus_master #(
    parameter int POLL_GAP = 2,
    parameter int POLL_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_GAP  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [1:0]  OP_WRITE = 2'd0;
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_POLL  = 2'd2;
    localparam logic [1:0]  OP_RSVD  = 2'd3;
    // Last value of the gap counter before the next poll read is issued.
    localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  op_r;
    logic [15:0] addr_r;
    logic [31:0] data_r;
    logic [15:0] gap_r;

    logic        accept_s;
    logic [1:0]  op_s;
    logic [15:0] addr_s;
    logic [31:0] data_s;
    logic        match_s;
    logic        timeout_hit_s;
    logic        poll_tmo_s;

    logic        ena_r;
    logic        wea_r;
    logic [15:0] addra_r;
    logic [31:0] dina_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;
    logic        rsp_timeout_r;

    logic        ena_nxt_s;
    logic        wea_nxt_s;
    logic [15:0] addra_nxt_s;
    logic [31:0] dina_nxt_s;
    logic        rsp_valid_nxt_s;
    logic [31:0] rsp_data_nxt_s;
    logic        rsp_err_nxt_s;
    logic        rsp_timeout_nxt_s;

    // Ready only when idle and not being reset, so a command presented with rst is ignored.
    assign cmd_ready = (state_r == ST_IDLE) && !rst;
    assign accept_s  = (state_r == ST_IDLE) && cmd_valid;

    // In IDLE the command has not been captured yet, so the live inputs feed the first bus cycle.
    assign op_s   = (state_r == ST_IDLE) ? cmd_op   : op_r;
    assign addr_s = (state_r == ST_IDLE) ? cmd_addr : addr_r;
    assign data_s = (state_r == ST_IDLE) ? cmd_data : data_r;

    // For POLL the command data word is the bit mask; mask 0 can never match.
    assign match_s    = (douta & data_r) != 32'd0;
    assign poll_tmo_s = (op_r == OP_POLL) && !match_s && timeout_hit_s;

`ifdef NPU_BUS_POLL_TIMEOUT_EN
    logic [10:0] poll_cnt_r;

    // Count reads issued for the current command; restarts on every accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt_r <= 11'd0;
        end else if (accept_s) begin
            poll_cnt_r <= 11'd0;
        end else if (state_r == ST_RD) begin
            poll_cnt_r <= poll_cnt_r + 11'd1;
        end else begin
            poll_cnt_r <= poll_cnt_r;
        end
    end

    assign timeout_hit_s = (poll_cnt_r == 11'(POLL_MAX));
`else
    // No read limit: POLL retries until the mask matches. POLL_MAX is legal only when >= 1,
    // so this term is constant 0.
    assign timeout_hit_s = (POLL_MAX < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: state_nxt_s = ST_WR;
                        OP_READ:  state_nxt_s = ST_RD;
                        OP_POLL:  state_nxt_s = ST_RD;
                        default:  state_nxt_s = ST_RSP;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR:  state_nxt_s = ST_RSP;
            ST_RD:  state_nxt_s = ST_CAP;
            ST_CAP: begin
                if (op_r != OP_POLL) begin
                    state_nxt_s = ST_RSP;
                end else if (match_s || timeout_hit_s) begin
                    state_nxt_s = ST_RSP;
                end else if (POLL_GAP == 0) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        ena_nxt_s   = 1'b0;
        wea_nxt_s   = 1'b0;
        addra_nxt_s = 16'd0;
        dina_nxt_s  = 32'd0;
        case (state_nxt_s)
            ST_WR: begin
                ena_nxt_s   = 1'b1;
                wea_nxt_s   = 1'b1;
                addra_nxt_s = addr_s;
                dina_nxt_s  = data_s;
            end
            ST_RD: begin
                ena_nxt_s   = 1'b1;
                addra_nxt_s = addr_s;
            end
            default: begin
                // Bus fully idle: the NPU decodes ctrl pulses from addra/dina even without ena.
                ena_nxt_s   = 1'b0;
            end
        endcase

        rsp_valid_nxt_s = (state_nxt_s == ST_RSP);
        rsp_err_nxt_s   = (state_nxt_s == ST_RSP) && (op_s == OP_RSVD);

        if ((state_r == ST_CAP) && (state_nxt_s == ST_RSP)) begin
            rsp_timeout_nxt_s = poll_tmo_s;
        end else if ((state_r == ST_RSP) && (state_nxt_s == ST_RSP)) begin
            rsp_timeout_nxt_s = rsp_timeout_r;
        end else begin
            rsp_timeout_nxt_s = 1'b0;
        end

        if (accept_s) begin
            rsp_data_nxt_s = 32'd0;
        end else if (state_r == ST_CAP) begin
            rsp_data_nxt_s = douta;
        end else begin
            rsp_data_nxt_s = rsp_data_r;
        end
    end

    // Output registers: bus and response outputs all come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_r         <= 1'b0;
            wea_r         <= 1'b0;
            addra_r       <= 16'd0;
            dina_r        <= 32'd0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            ena_r         <= ena_nxt_s;
            wea_r         <= wea_nxt_s;
            addra_r       <= addra_nxt_s;
            dina_r        <= dina_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_data_r    <= rsp_data_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
        end
    end

    // Capture the accepted command so later poll retries reuse address and mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= 2'd0;
            addr_r <= 16'd0;
            data_r <= 32'd0;
        end else if (accept_s) begin
            op_r   <= cmd_op;
            addr_r <= cmd_addr;
            data_r <= cmd_data;
        end else begin
            op_r   <= op_r;
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    // Idle cycles between poll reads; zero outside the GAP state.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_r <= 16'd0;
        end else if (state_r == ST_GAP) begin
            gap_r <= gap_r + 16'd1;
        end else begin
            gap_r <= 16'd0;
        end
    end

    assign ena         = ena_r;
    assign wea         = wea_r;
    assign addra       = addra_r;
    assign dina        = dina_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_npu_bus_master.sv
// Testbench for npu_bus_master: table-driven directed vectors, hand-written
// reset/timeout sequences and randomized commands against a reference model.
module tb_npu_bus_master;

    localparam int G    = 2;
    localparam int PMAX = 4;
`ifdef NPU_BUS_POLL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;

    int n_vec = 0;
    int n_bad = 0;

    // Read values the NPU model returns for the current command, in order.
    logic [31:0] pv [8];
    int          pn = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;

    npu_bus_master #(.POLL_GAP(G), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NPU model: registered read data one cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        if (ena && !wea) begin
            douta  <= ((rd_cnt - rd_base) < pn) ? pv[3'(rd_cnt - rd_base)] : 32'h0;
            rd_cnt <= rd_cnt + 1;
        end else begin
            douta  <= $urandom;
        end
    end

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %h want %h", nm, t, act, exp);
        end
    endtask

    // Reference model: expected read count and response from the command rules.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] mask,
                                      output int reads, output logic [31:0] d,
                                      output logic err, output logic tmo);
        logic [31:0] v;
        reads = 0; d = 32'h0; err = 1'b0; tmo = 1'b0;
        case (op)
            2'd0: reads = 0;
            2'd1: begin reads = 1; d = (pn > 0) ? pv[0] : 32'h0; end
            2'd2: begin
                for (int i = 0; i < 64; i++) begin
                    v = (i < pn) ? pv[i] : 32'h0;
                    reads = i + 1;
                    d = v;
                    if ((v & mask) != 32'h0) break;
                    if (TMO_EN && reads == PMAX) begin tmo = 1'b1; break; end
                end
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Issue one command and check every cycle up to and through the response handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                          input int hold, input int reads, input logic [31:0] exp_d,
                          input logic exp_err, input logic exp_tmo, input string nm);
        int lat;
        logic is_rd, is_wr, e_ena;
        case (op)
            2'd0:    lat = 2;
            2'd1:    lat = 3;
            2'd2:    lat = 1 + (reads - 1) * (2 + G) + 2;
            default: lat = 1;
        endcase
        rd_base = rd_cnt;
        @(negedge clk);
        chk({nm, "/cmd_ready_idle"}, 0, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int t = 1; t <= lat; t++) begin
            @(negedge clk);
            is_wr = (op == 2'd0) && (t == 1);
            is_rd = ((op == 2'd1) || (op == 2'd2)) && (((t - 1) % (2 + G)) == 0)
                    && (((t - 1) / (2 + G)) < reads);
            e_ena = is_wr || is_rd;
            chk({nm, "/ena"},   t, ena,   e_ena);
            chk({nm, "/wea"},   t, wea,   is_wr);
            chk({nm, "/addra"}, t, addra, e_ena ? addr : 16'h0);
            chk({nm, "/dina"},  t, dina,  is_wr ? data : 32'h0);
            chk({nm, "/rsp_valid"}, t, rsp_valid, (t == lat));
            chk({nm, "/cmd_ready_busy"}, t, cmd_ready, 1'b0);
        end
        chk({nm, "/rsp_data"},    lat, rsp_data,    exp_d);
        chk({nm, "/rsp_err"},     lat, rsp_err,     exp_err);
        chk({nm, "/rsp_timeout"}, lat, rsp_timeout, exp_tmo);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk({nm, "/hold_valid"}, lat + h, rsp_valid, 1'b1);
            chk({nm, "/hold_data"},  lat + h, rsp_data,  exp_d);
            chk({nm, "/hold_err"},   lat + h, rsp_err,   exp_err);
            chk({nm, "/hold_tmo"},   lat + h, rsp_timeout, exp_tmo);
            chk({nm, "/hold_busy"},  lat + h, cmd_ready, 1'b0);
            chk({nm, "/hold_bus"},   lat + h, {ena, wea, addra, 14'h0} | dina, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "/post_valid"}, -1, rsp_valid, 1'b0);
        chk({nm, "/post_ready"}, -1, cmd_ready, 1'b1);
        chk({nm, "/post_ena"},   -1, ena, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] v0, v1, v2;
        int          nv;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_reads;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          reads;
        logic [31:0] ed, mask;
        logic        ee, et;
        logic [1:0]  op;
        int          n;

        tbl[0] = '{2'd0, 16'h1000, 32'h00030201, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 0};
        tbl[1] = '{2'd1, 16'h6000, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1, 2, 32'hDEADBEEF, 1'b0, 1};
        tbl[2] = '{2'd2, 16'h7000, 32'h1, 32'h0, 32'h0, 32'h1, 3, 0, 32'h1, 1'b0, 3};
        tbl[3] = '{2'd3, 16'h4000, 32'h5, 32'h0, 32'h0, 32'h0, 0, 5, 32'h0, 1'b1, 0};
        tbl[4] = '{2'd2, 16'h5000, 32'h80000000, 32'h7FFFFFFF, 32'h80000001, 32'h0, 2, 1, 32'h80000001, 1'b0, 2};
        tbl[5] = '{2'd0, 16'h4001, 32'h1, 32'h0, 32'h0, 32'h0, 0, 3, 32'h0, 1'b0, 0};
        tbl[6] = '{2'd1, 16'h2ABC, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1'b0, 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 16'h0; cmd_data = 32'h0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/cmd_ready_in_rst", 0, cmd_ready, 1'b0);
        chk("reset/ena_in_rst", 0, ena, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset/cmd_ready", 0, cmd_ready, 1'b1);
        chk("reset/bus", 0, {ena, wea, addra, 14'h0} | dina, 32'h0);
        chk("reset/rsp_valid", 0, rsp_valid, 1'b0);
        chk("reset/rsp_err", 0, rsp_err, 1'b0);
        chk("reset/rsp_timeout", 0, rsp_timeout, 1'b0);
        chk("reset/rsp_data", 0, rsp_data, 32'h0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            pv[0] = tbl[i].v0; pv[1] = tbl[i].v1; pv[2] = tbl[i].v2; pn = tbl[i].nv;
            do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].hold, tbl[i].exp_reads,
                   tbl[i].exp_data, tbl[i].exp_err, 1'b0, $sformatf("tbl%0d", i));
        end

        // Reset asserted while a POLL sits in its gap; a command offered with rst is ignored.
        pv[0] = 32'h2; pn = 1; rd_base = rd_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 16'h7000; cmd_data = 32'h1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstgap/first_read", 1, ena, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rstgap/gap_idle", 3, ena, 1'b0);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 16'h4001; cmd_data = 32'h1;
        #1 chk("rstgap/ready_in_rst", 3, cmd_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstgap/bus", 4, {ena, wea, addra, 14'h0} | dina, 32'h0);
        chk("rstgap/rsp_valid", 4, rsp_valid, 1'b0);
        chk("rstgap/rsp_data", 4, rsp_data, 32'h0);
        chk("rstgap/rsp_flags", 4, {rsp_err, rsp_timeout}, 2'b00);
        chk("rstgap/cmd_ready", 4, cmd_ready, 1'b1);
        @(negedge clk);
        chk("rstgap/no_replay_ena", 5, ena, 1'b0);
        chk("rstgap/no_replay_rsp", 5, rsp_valid, 1'b0);
        pn = 0;
        do_cmd(2'd0, 16'h1000, 32'h00030201, 0, 0, 32'h0, 1'b0, 1'b0, "rstgap_write");

`ifdef NPU_BUS_POLL_TIMEOUT_EN
        // Exhausted poll: exactly PMAX reads, last value returned with timeout set.
        pv[0] = 32'h2; pv[1] = 32'h4; pv[2] = 32'h6; pv[3] = 32'h8; pv[4] = 32'h1; pn = 5;
        do_cmd(2'd2, 16'h7000, 32'h1, 2, PMAX, 32'h8, 1'b0, 1'b1, "tmo_nomatch");
        pv[0] = 32'h1; pv[1] = 32'h3; pv[2] = 32'h5; pv[3] = 32'h7; pn = 4;
        do_cmd(2'd2, 16'h5000, 32'h0, 0, PMAX, 32'h7, 1'b0, 1'b1, "tmo_mask0");
`endif

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            cmd_addr = {1'b0, 3'($urandom_range(1, 7)), 12'($urandom)};
            mask = $urandom;
            pn = 0;
            if (op == 2'd2) begin
                if (mask == 32'h0) mask = 32'h1;
                n = $urandom_range(1, 5);
                for (int i = 0; i < n - 1; i++) pv[i] = $urandom & ~mask;
                pv[n - 1] = ($urandom & mask) | (mask & (~mask + 32'h1));
                pn = n;
            end else if (op == 2'd1) begin
                pv[0] = $urandom; pn = 1;
            end
            ref_model(op, mask, reads, ed, ee, et);
            do_cmd(op, cmd_addr, mask, $urandom_range(0, 3), reads, ed, ee, et,
                   $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
